arb_mux_2to1: RTL

ARB_MUX_2TO1 -- requirements
Module: arb_mux_2to1

---
 rtl/arb_mux_pkg.sv | 13 +
 rtl/arb_mux_2to1_out_stage.sv | 39 +++
 rtl/arb_mux_2to1.sv | 94 +++++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
// Shared types and constants for the two-input packet arbiter/mux.
// Holds the arbiter state encoding and the default payload width.
package arb_mux_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

endpackage

// File: rtl/arb_mux_2to1_out_stage.sv
// Registered output beat of the arbiter.
// Tracks occupancy and reports when a new beat may be loaded.
module out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] beat_data,
  input  logic              beat_last,
  input  logic              beat_sel,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_sel,
  output logic              out_free
);

  assign out_free = !m_valid || m_ready;

  // Load wins over unload so back-to-back beats never bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_sel   <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= beat_data;
      m_last  <= beat_last;
      m_sel   <= beat_sel;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/arb_mux_2to1.sv
// Two-source packet arbiter: round-robin per packet, no interleaving.
// A granted source holds the output until its last beat is accepted.
module arb_mux_2to1
  import arb_mux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_sel
);

  state_t state, state_n;
  logic   prio, prio_n;
  logic   out_free;
  logic   gnt0, gnt1;
  logic   acc, sel, last;

  assign acc  = (s0_valid && s0_ready) || (s1_valid && s1_ready);
  assign sel  = s1_ready;
  assign last = sel ? s1_last : s0_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_n;
      prio  <= prio_n;
    end
  end

  always_comb begin
    state_n = state;
    prio_n  = prio;
    if (acc) begin
      if (last) begin
        state_n = IDLE;
        prio_n  = !sel;
      end else begin
        state_n = sel ? LOCK1 : LOCK0;
      end
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state)
      LOCK0: gnt0 = s0_valid;
      LOCK1: gnt1 = s1_valid;
      default: begin
        if (s0_valid && s1_valid) begin
          gnt0 = !prio;
          gnt1 = prio;
        end else begin
          gnt0 = s0_valid;
          gnt1 = s1_valid;
        end
      end
    endcase
  end

  assign s0_ready = !rst && out_free && gnt0;
  assign s1_ready = !rst && out_free && gnt1;

  out_stage #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (acc),
    .beat_data (sel ? s1_data : s0_data),
    .beat_last (last),
    .beat_sel  (sel),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_sel     (m_sel),
    .out_free  (out_free)
  );

endmodule
